// File: rtl/softmax_sched_pkg.sv
// Shared types and default constants for the softmax engine scheduler.
// Imported by the scheduler top and by anything that decodes its state.
package softmax_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

    localparam int DEF_TIMEOUT      = 16;
    localparam int DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/softmax_sched_if.sv
// Requester-side and engine-side signals of the shared softmax scheduler.
// slave = the scheduler itself, master = requesters plus engine.
interface softmax_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int VEC_SIZE   = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                          req;
    logic [NUM_REQ-1:0][VEC_SIZE-1:0][DATA_WIDTH-1:0] req_vec;
    logic [NUM_REQ-1:0]                          done;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]         res_vec;
    logic                                        err;
    logic                                        busy;
    logic [IDX_W-1:0]                            gnt_id;
    logic                                        sm_enable;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]         sm_vec_in;
    logic                                        sm_data_valid;
    logic [VEC_SIZE-1:0][DATA_WIDTH-1:0]         sm_vec_out;

    modport slave (
        input  req, req_vec, sm_data_valid, sm_vec_out,
        output done, res_vec, err, busy, gnt_id, sm_enable, sm_vec_in
    );

    modport master (
        output req, req_vec, sm_data_valid, sm_vec_out,
        input  done, res_vec, err, busy, gnt_id, sm_enable, sm_vec_in
    );

endinterface

// File: rtl/softmax_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after rr_ptr, wrapping. Reusable by any shared-engine scheduler.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    // Scan from the farthest offset down to rr_ptr so the nearest hit wins last.
    always_comb begin : arb
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                gnt_idx = IDX_W'(idx);
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/softmax_sched.sv
// Round-robin scheduler sharing one softmax engine among NUM_REQ requesters:
// latches the winner's operand, holds enable until valid or timeout, then drains.
module softmax_sched
    import softmax_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int VEC_SIZE     = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int FIXED_PNT    = 8,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    softmax_sched_if.slave bus
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    // The mandatory IDLE cycle before the next grant is the last enable-low
    // cycle of the gap, so DRAIN itself is one cycle shorter.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    typedef logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

    if (NUM_REQ < 2 || TIMEOUT < 4 || DRAIN_CYCLES < 4 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_params
        $error("softmax_sched: illegal parameter combination");
    end

    sched_state_t       state, state_nxt;
    logic [CNT_W-1:0]   tmo_cnt, cnt_nxt;
    logic [IDX_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               grant, capture, timeout;

    logic [NUM_REQ-1:0] gnt_oh_q;
    logic [NUM_REQ-1:0] done_q;
    logic               err_q;
    logic               busy_q;
    logic [IDX_W-1:0]   gnt_id_q;
    logic               sm_enable_q;
    vec_t               sm_vec_in_q;
    vec_t               res_vec_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = tmo_cnt + 1'b1;
        grant     = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (arb_any) begin
                    grant     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // A valid that lands on the timeout cycle still wins.
                if (bus.sm_data_valid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (tmo_cnt == DRAIN_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= cnt_nxt;
        end
    end

    // The served requester drops to lowest priority once its done is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == DONE) begin
            rr_ptr <= (gnt_id_q == LAST_IDX) ? '0 : gnt_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_oh_q    <= '0;
            gnt_id_q    <= '0;
            sm_vec_in_q <= '0;
            res_vec_q   <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            sm_enable_q <= 1'b0;
        end else begin
            sm_enable_q <= (state_nxt == RUN);
            busy_q      <= (state_nxt != IDLE);
            done_q      <= '0;
            err_q       <= 1'b0;
            if (grant) begin
                gnt_oh_q    <= arb_gnt;
                gnt_id_q    <= arb_idx;
                sm_vec_in_q <= bus.req_vec[arb_idx];
            end
            if (capture) begin
                res_vec_q <= bus.sm_vec_out;
            end
            if (capture || timeout) begin
                done_q <= gnt_oh_q;
                err_q  <= timeout;
            end
        end
    end

    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.sm_enable = sm_enable_q;
    assign bus.sm_vec_in = sm_vec_in_q;
    assign bus.res_vec   = res_vec_q;

endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched with a latency-programmable engine stub
// whose result is the bitwise inverse of the operand.
module tb_softmax_sched;

    localparam int NUM_REQ      = 4;
    localparam int VEC_SIZE     = 8;
    localparam int DATA_WIDTH   = 16;
    localparam int FIXED_PNT    = 8;
    localparam int TIMEOUT      = 16;
    localparam int DRAIN_CYCLES = 4;

    typedef logic [VEC_SIZE-1:0][DATA_WIDTH-1:0] vec_t;
    localparam vec_t JUNK = {VEC_SIZE{16'h1234}};

    typedef struct {
        logic [3:0] req;
        logic [7:0] lat;
        int         exp_gnt;
        int         exp_lat;
        logic       exp_err;
    } vec_rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    softmax_sched_if #(.NUM_REQ(NUM_REQ), .VEC_SIZE(VEC_SIZE), .DATA_WIDTH(DATA_WIDTH)) bus ();

    softmax_sched #(
        .NUM_REQ      (NUM_REQ),
        .VEC_SIZE     (VEC_SIZE),
        .DATA_WIDTH   (DATA_WIDTH),
        .FIXED_PNT    (FIXED_PNT),
        .TIMEOUT      (TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] stub_lat = 8'd3;
    logic [7:0] en_cnt   = 8'd0;
    logic       force_valid = 1'b0;

    always @(posedge clk) begin
        if (!bus.sm_enable) en_cnt <= 8'd0;
        else if (en_cnt != 8'hFF) en_cnt <= en_cnt + 8'd1;
    end
    assign bus.sm_data_valid = force_valid || (bus.sm_enable && en_cnt == stub_lat);
    assign bus.sm_vec_out    = force_valid ? JUNK : ~bus.sm_vec_in;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NUM_REQ];
    vec_t exp_res;
    vec_rec_t tbl [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int ok = 0;
        for (int c = 0; c < 20 && ok == 0; c++) begin
            step();
            if (bus.sm_enable) ok = 1;
        end
        check({name, "_grant_seen"}, ok, 1);
    endtask

    task automatic wait_done(input string name, output int lat, output int en_cyc);
        int ok = 0;
        lat = 0;
        en_cyc = 1;
        for (int c = 0; c < 40 && ok == 0; c++) begin
            step();
            lat++;
            if (bus.done != '0) ok = 1;
            else if (bus.sm_enable) en_cyc++;
        end
        check({name, "_done_seen"}, ok, 1);
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        int en_hi = 0;
        for (int c = 0; c < 30 && ok == 0; c++) begin
            if (!bus.busy) ok = 1;
            else begin
                if (bus.sm_enable) en_hi++;
                step();
            end
        end
        check({name, "_idle_seen"}, ok, 1);
        check({name, "_drain_enable_low"}, en_hi, 0);
    endtask

    initial begin
        int lat, en_cyc;
        int gids [5];
        int gcyc [5];
        int ng, width_err, cyc;
        logic prev_en, prev_done;
        logic [3:0] exp_done;

        for (int r = 0; r < NUM_REQ; r++) begin
            for (int e = 0; e < VEC_SIZE; e++) begin
                vecs[r][e] = 16'(256 * (r + 1) + e);
            end
            bus.req_vec[r] = vecs[r];
        end
        vecs[0][0] = 16'h0100;
        bus.req_vec[0] = vecs[0];

        tbl[0] = '{4'b0001, 8'd3,   0, 4,  1'b0};
        tbl[1] = '{4'b0101, 8'd3,   2, 4,  1'b0};
        tbl[2] = '{4'b0011, 8'd5,   0, 6,  1'b0};
        tbl[3] = '{4'b1000, 8'd200, 3, 16, 1'b1};
        tbl[4] = '{4'b0010, 8'd15,  1, 16, 1'b0};
        tbl[5] = '{4'b1011, 8'd1,   3, 2,  1'b0};
        tbl[6] = '{4'b0110, 8'd0,   1, 1,  1'b0};

        // Reset values, with a request pending that must not be served.
        rst = 1'b1;
        bus.req = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sm_enable", bus.sm_enable, 0);
        check("rst_sm_vec_in", bus.sm_vec_in, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gnt_id", bus.gnt_id, 0);
        check("rst_res_vec", bus.res_vec, 0);
        bus.req = 4'b0000;
        rst = 1'b0;
        step();
        exp_res = '0;

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            stub_lat = tbl[i].lat;
            bus.req = tbl[i].req;
            wait_grant(nm);
            check({nm, "_gnt_id"}, bus.gnt_id, tbl[i].exp_gnt);
            check({nm, "_sm_vec_in"}, bus.sm_vec_in, vecs[tbl[i].exp_gnt]);
            wait_done(nm, lat, en_cyc);
            exp_done = '0;
            exp_done[tbl[i].exp_gnt] = 1'b1;
            if (!tbl[i].exp_err) exp_res = ~vecs[tbl[i].exp_gnt];
            check({nm, "_latency"}, lat, tbl[i].exp_lat);
            check({nm, "_enable_cycles"}, en_cyc, tbl[i].exp_lat);
            check({nm, "_done"}, bus.done, exp_done);
            check({nm, "_err"}, bus.err, tbl[i].exp_err);
            check({nm, "_res_vec"}, bus.res_vec, exp_res);
            bus.req = 4'b0000;
            step();
            check({nm, "_done_width"}, bus.done, 0);
            check({nm, "_err_width"}, bus.err, 0);
            wait_idle(nm);
        end

        // Stray engine valid while idle is ignored.
        force_valid = 1'b1;
        step();
        force_valid = 1'b0;
        step();
        check("stray_res_vec", bus.res_vec, exp_res);
        check("stray_busy", bus.busy, 0);
        check("stray_done", bus.done, 0);

        // All requesters held: strict rotation with 9-cycle spacing.
        rst = 1'b1;
        step();
        rst = 1'b0;
        stub_lat = 8'd3;
        bus.req = 4'b1111;
        ng = 0; width_err = 0; prev_en = 1'b0; prev_done = 1'b0;
        for (cyc = 1; cyc <= 42; cyc++) begin
            step();
            if (bus.sm_enable && !prev_en && ng < 5) begin
                gids[ng] = int'(bus.gnt_id);
                gcyc[ng] = cyc;
                ng++;
            end
            if (bus.done != '0) begin
                if (prev_done) width_err++;
                if (!$onehot(bus.done)) width_err++;
            end
            prev_en = bus.sm_enable;
            prev_done = (bus.done != '0);
        end
        check("rot_grants", ng, 5);
        check("rot_id0", gids[0], 0);
        check("rot_id1", gids[1], 1);
        check("rot_id2", gids[2], 2);
        check("rot_id3", gids[3], 3);
        check("rot_id4", gids[4], 0);
        for (int k = 1; k < 5; k++) begin
            check($sformatf("rot_spacing%0d", k), gcyc[k] - gcyc[k-1], 9);
        end
        check("rot_done_width", width_err, 0);
        bus.req = 4'b0000;
        wait_idle("rot");

        // Withdrawn request still completes; next pending requester follows.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 4'b1100;
        wait_grant("wd");
        check("wd_gnt_id", bus.gnt_id, 2);
        step();
        bus.req = 4'b1000;
        wait_done("wd", lat, en_cyc);
        check("wd_done", bus.done, 4'b0100);
        check("wd_res_vec", bus.res_vec, ~vecs[2]);
        wait_grant("wd_next");
        check("wd_next_gnt_id", bus.gnt_id, 3);
        bus.req = 4'b0000;
        wait_done("wd_next", lat, en_cyc);
        check("wd_next_done", bus.done, 4'b1000);
        wait_idle("wd");

        // Move rr_ptr to 2, then reset mid-RUN.
        bus.req = 4'b0010;
        wait_grant("pre");
        wait_done("pre", lat, en_cyc);
        check("pre_done", bus.done, 4'b0010);
        bus.req = 4'b0000;
        wait_idle("pre");
        bus.req = 4'b1010;
        wait_grant("mr");
        check("mr_gnt_id", bus.gnt_id, 3);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("mr_async_sm_enable", bus.sm_enable, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_gnt_id_rst", bus.gnt_id, 0);
        check("mr_res_vec_rst", bus.res_vec, 0);
        check("mr_sm_vec_in_rst", bus.sm_vec_in, 0);
        step();
        check("mr_no_done", bus.done, 0);
        rst = 1'b0;
        wait_grant("mr_after");
        check("mr_after_gnt_id", bus.gnt_id, 1);
        wait_done("mr_after", lat, en_cyc);
        check("mr_after_done", bus.done, 4'b0010);
        check("mr_after_res_vec", bus.res_vec, ~vecs[1]);
        bus.req = 4'b0000;
        wait_idle("mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
